aes_inv_rounds_seq: RTL
=======================

// Module: aes_inv_rounds_seq
// PURPOSE
// Iterative AES-128 inverse cipher: one inverse round per clock, with on-the-fly reverse key schedule.
// Decryption counterpart of the forward round datapath (KeyGeneration/subbytes/shiftrow/mixcolumn).
// Sits beside the encrypt engine in the riscv/aes IP; the bus-side wrapper drives it via valid/ready.
// Byte order follows FIPS-197: byte0 = bits[127:120], state filled column-major.
// PARAMETERS
// NR          10  number of rounds; only 10 (AES-128) is supported, elaborate-time error otherwise
// KEY_IS_LAST 1   1: key_in is final round key k10; 0: key_in is cipher key k0, forward-expanded first
// PORTS
// clk        in   1    clock, all flops rising-edge
// rst_n      in   1    asynchronous active-low reset
// in_valid   in   1    ciphertext/key request valid
// in_ready   out  1    engine can accept a request (state==IDLE)
// ct_in      in   128  ciphertext block
// key_in     in   128  key (k10 or k0 per KEY_IS_LAST)
// out_valid  out  1    pt_out/dkey_out valid; held until out_ready
// out_ready  in   1    consumer accepts result
// pt_out     out  128  plaintext block
// dkey_out   out  128  k10 used for this block (decryption key, for host caching)
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, round ctr=0, in_ready=0 during reset then 1, out_valid=0,
//   pt_out=0, dkey_out=0. Reset mid-operation aborts the block; no partial result is ever flagged.
// - FSM: IDLE -> (KEXP if KEY_IS_LAST=0) -> ROUND -> FINAL -> DONE -> IDLE.
// - IDLE: in_ready=1. Accept on in_valid&&in_ready at edge E0:
//   KEY_IS_LAST=1: st<=ct_in^key_in, rk<=key_in, r<=9, go ROUND.
//   KEY_IS_LAST=0: ct latched, rk<=key_in, r<=1, go KEXP.
// - KEXP: rk<=fwd_expand(rk,Rcon[r]), r++ per cycle; after k10 formed (10 cycles) st<=ct^k10, r<=9, ROUND.
// - Reverse key step k(r-1) from k(r), words w0..w3 MSW first:
//   w3'=w3^w2; w2'=w2^w1; w1'=w1^w0; w0'=w0^SubWord(RotWord(w3'))^Rcon[r]<<24.
//   Rcon[1..10]=01,02,04,08,10,20,40,80,1b,36.
// - ROUND (r=9..1, one per cycle): rk<=k(r) from k(r+1);
//   st<=InvMixColumns(InvSubBytes(InvShiftRows(st))^k(r)); r--; after r=1 go FINAL.
// - FINAL: st<=InvSubBytes(InvShiftRows(st))^k0; pt_out<=result, out_valid<=1, go DONE.
// - dkey_out captured when k10 is first available; stable through DONE.
// - Latency accept->out_valid: 10 cycles (KEY_IS_LAST=1), 20 cycles (KEY_IS_LAST=0).
// - DONE: out_valid=1, in_ready=0; pt_out/dkey_out stable. On out_ready=1 -> IDLE, out_valid<=0
//   at that edge. A new request is not accepted in the same cycle (in_ready decodes from state).
// - in_valid while busy is ignored (no queuing); ct_in/key_in need only be valid at the accept edge.
// - out_ready while out_valid=0 has no effect. Back-to-back throughput: 1 block / 12 cycles (KIL=1).
// - All arithmetic is GF(2^8) / XOR, no carries; round ctr is 4 bits, never wraps past 0 or 10.
// TESTING
// T1 KIL=1: ct=69c4e0d86a7b0430d8cdb78070b4c55a, key=13111d7fe3944a17f307a78b4d2b30c5
//    -> pt_out=00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after accept.
// T2 KIL=0: ct=3925841d02dc09fbdc118597196a0b32, key=2b7e151628aed2a6abf7158809cf4f3c
//    -> pt_out=3243f6a8885a308d313198a2e0370734, dkey_out=d014f9a8c9ee2589e13f0cc8b6630ca6, latency 20.
// T3 Backpressure: hold out_ready=0 for 50 cycles after T1 result -> out_valid,pt_out stable,
//    in_ready=0, in_valid pulses ignored; release -> one handshake, IDLE next cycle.
// T4 Reset mid-run: rst_n=0 at round 5 of T1 -> out_valid=0, pt_out=0 immediately;
//    release, rerun T1 -> correct pt, no stale output.
// T5 Busy-drop: assert in_valid with different ct during ROUND -> result still equals T1 vector.
// T6 Random: 1000 vectors vs reference model encrypt/decrypt round-trip, random out_ready stalls.

Source files
------------

// File: rtl/aes_inv_rounds_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aes_inv_rounds_seq
// Brief    : Iterative AES-128 inverse cipher, one inverse round per clock,
//            reverse key schedule computed on the fly.
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_rounds_seq #(
  parameter int NR          = 10,
  parameter bit KEY_IS_LAST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_ct,
  input  logic [127:0] i_key,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_pt,
  output logic [127:0] o_dkey
);

  generate
    if (NR != 10) begin : g_bad_nr
      $error("aes_inv_rounds_seq: only NR=10 (AES-128) is supported");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEXP  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0 as AES requires).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240;
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a12  = gmul(gmul(a3, a3), gmul(a3, a3));
    a15  = gmul(a12, a3);
    a240 = gmul(a15, a15);
    a240 = gmul(a240, a240);
    a240 = gmul(a240, a240);
    a240 = gmul(a240, a240);
    return gmul(gmul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return ginv(y);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] rev_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // State byte b = 4*col + row sits at bits [127-8b -: 8].
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(8'h0e, a0) ^ gmul(8'h0b, a1) ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3);
      o[119-32*c -: 8] = gmul(8'h09, a0) ^ gmul(8'h0e, a1) ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3);
      o[111-32*c -: 8] = gmul(8'h0d, a0) ^ gmul(8'h09, a1) ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3);
      o[103-32*c -: 8] = gmul(8'h0b, a0) ^ gmul(8'h0d, a1) ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3);
    end
    return o;
  endfunction

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic [127:0] r_st;
  logic [127:0] r_rk;
  logic [127:0] r_ct;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [127:0] r_pt;
  logic [127:0] r_dkey;

  logic [3:0]   w_cnt_p1;
  logic [127:0] w_k_prev;
  logic [127:0] w_k_next;
  logic [127:0] w_final;
  logic [127:0] w_round;

  // r_rk holds k(r+1) while the counter reads r, hence Rcon[r+1] on the way down.
  assign w_cnt_p1 = r_cnt + 4'd1;
  assign w_k_prev = rev_step(r_rk, rcon(w_cnt_p1));
  assign w_k_next = fwd_step(r_rk, rcon(r_cnt));
  assign w_final  = inv_shift_sub(r_st) ^ w_k_prev;
  assign w_round  = inv_mix(w_final);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_st        <= '0;
      r_rk        <= '0;
      r_ct        <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_pt        <= '0;
      r_dkey      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_rk       <= i_key;
            if (KEY_IS_LAST) begin
              r_st    <= i_ct ^ i_key;
              r_dkey  <= i_key;
              r_cnt   <= 4'd9;
              r_state <= S_ROUND;
            end else begin
              r_ct    <= i_ct;
              r_cnt   <= 4'd1;
              r_state <= S_KEXP;
            end
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_KEXP: begin
          r_rk <= w_k_next;
          if (r_cnt == 4'd10) begin
            r_st    <= r_ct ^ w_k_next;
            r_dkey  <= w_k_next;
            r_cnt   <= 4'd9;
            r_state <= S_ROUND;
          end else begin
            r_cnt <= w_cnt_p1;
          end
        end
        S_ROUND: begin
          r_st  <= w_round;
          r_rk  <= w_k_prev;
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_FINAL;
        end
        S_FINAL: begin
          r_st        <= w_final;
          r_rk        <= w_k_prev;
          r_pt        <= w_final;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_pt        = r_pt;
  assign o_dkey      = r_dkey;

endmodule
`default_nettype wire
